// File: rtl/boot_loader_stream_if.sv
// Stream-in / memory-write-out bundle for boot_loader_stream.
// The loader uses the slave modport; the byte source and ROM side use master.
interface boot_loader_stream_if #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
);
  localparam int BYTES = DBITS / 8;

  logic [7:0]       s_data_i;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [ABITS-1:0] waddr_o;
  logic [DBITS-1:0] din_o;
  logic             we_o;
  logic [BYTES-1:0] be_o;

  modport slave (
    input  s_data_i, s_valid_i,
    output s_ready_o, waddr_o, din_o, we_o, be_o
  );

  modport master (
    output s_data_i, s_valid_i,
    input  s_ready_o, waddr_o, din_o, we_o, be_o
  );
endinterface

// File: rtl/boot_loader_stream.sv
// Framed byte-stream boot loader: 16-bit length header, payload packed little-endian into DBITS words.
// Define BOOT_LOADER_CSUM_EN to expect a trailing 1-byte XOR checksum after the payload.
module boot_loader_stream #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  boot_loader_stream_if.slave   bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);
  localparam int BYTES = DBITS / 8;
  localparam int LW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [31:0] MAX_LEN = 32'(BYTES) << ABITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [15:0]      rem_q, rem_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [DBITS-1:0] buf_q, buf_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [ABITS-1:0] waddr_q, waddr_d;
  logic [DBITS-1:0] din_q, din_d;
  logic [BYTES-1:0] be_q, be_d;
  logic             we_q, we_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef BOOT_LOADER_CSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             hs;
  logic [15:0]      len_full;
  logic [DBITS-1:0] word_nxt;
  logic [BYTES-1:0] be_nxt;
  logic             word_end;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    buf_d    = buf_q;
    addr_d   = addr_q;
    waddr_d  = waddr_q;
    din_d    = din_q;
    be_d     = be_q;
    we_d     = 1'b0;
    done_d   = done_q;
    error_d  = error_q;
`ifdef BOOT_LOADER_CSUM_EN
    csum_d   = csum_q;
`endif

    hs       = bus.s_valid_i & ready_q;
    len_full = {bus.s_data_i, len_lo_q};
    word_nxt = buf_q;
    word_nxt[8*int'(lane_q) +: 8] = bus.s_data_i;
    for (int k = 0; k < BYTES; k++) begin
      be_nxt[k] = (k <= int'(lane_q));
    end
    word_end = (lane_q == LW'(BYTES - 1)) || (rem_q == 16'd1);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN0;
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = '0;
          lane_d  = '0;
          buf_d   = '0;
`ifdef BOOT_LOADER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN0: begin
        if (hs) begin
          len_lo_d = bus.s_data_i;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (hs) begin
          if (len_full == 16'd0 || {16'd0, len_full} > MAX_LEN) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
            rem_d   = len_full;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
`ifdef BOOT_LOADER_CSUM_EN
          csum_d = csum_q ^ bus.s_data_i;
`endif
          rem_d = rem_q - 16'd1;
          // Buffer is cleared after each write so a short final word has zero upper lanes.
          if (word_end) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            din_d   = word_nxt;
            be_d    = be_nxt;
            addr_d  = addr_q + 1'b1;
            lane_d  = '0;
            buf_d   = '0;
          end else begin
            buf_d  = word_nxt;
            lane_d = lane_q + 1'b1;
          end
          if (rem_q == 16'd1) begin
`ifdef BOOT_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef BOOT_LOADER_CSUM_EN
      S_CSUM: begin
        if (hs) begin
          if (bus.s_data_i == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
              (state_d == S_DATA) || (state_d == S_CSUM);
    busy_d  = ready_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      rem_q    <= '0;
      lane_q   <= '0;
      buf_q    <= '0;
      addr_q   <= '0;
      waddr_q  <= '0;
      din_q    <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef BOOT_LOADER_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      buf_q    <= buf_d;
      addr_q   <= addr_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
      be_q     <= be_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef BOOT_LOADER_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign bus.s_ready_o = ready_q;
  assign bus.waddr_o   = waddr_q;
  assign bus.din_o     = din_q;
  assign bus.be_o      = be_q;
  assign bus.we_o      = we_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
endmodule
